// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_reg
//  Brief    : Elastic valid/ready pipeline register with synchronous flush,
//             programmable bubble payload and a saturating stall counter.
//             Define PIPE_STAGE_SKID_EN to add a second (skid) entry that
//             registers in_ready and cuts the out_ready -> in_ready path.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter int               CNT_W  = 8
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_accept;
  logic             w_drain;

  // Flush masks the held beat the same cycle so downstream sees a bubble.
  assign out_valid = r_valid & ~flush;
  assign out_data  = out_valid ? r_data : BUBBLE;
  assign w_accept  = in_valid & in_ready;
  assign w_drain   = out_valid & out_ready;
  assign stall_cnt = r_stall_cnt;

`ifdef PIPE_STAGE_SKID_EN
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_skid_data;

  // Ready depends only on the skid flag, never on out_ready.
  assign in_ready = ~r_skid_valid & ~flush;

  // Two-entry FIFO: main feeds the output, skid catches a beat taken while main stalls.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_valid      <= 1'b0;
      r_data       <= BUBBLE;
      r_skid_valid <= 1'b0;
      r_skid_data  <= BUBBLE;
    end else if (flush) begin
      r_valid      <= 1'b0;
      r_data       <= BUBBLE;
      r_skid_valid <= 1'b0;
      r_skid_data  <= BUBBLE;
    end else if (w_drain || !r_valid) begin
      // Main slot frees up: refill from skid first to keep FIFO order.
      if (r_skid_valid) begin
        r_valid      <= 1'b1;
        r_data       <= r_skid_data;
        r_skid_valid <= 1'b0;
        r_skid_data  <= BUBBLE;
      end else if (w_accept) begin
        r_valid <= 1'b1;
        r_data  <= in_data;
      end else begin
        r_valid <= 1'b0;
        r_data  <= BUBBLE;
      end
    end else if (w_accept) begin
      // Main is held by back-pressure; park the new beat in skid.
      r_skid_valid <= 1'b1;
      r_skid_data  <= in_data;
    end
  end
`else
  // Single entry: a drain in the same cycle frees the slot for a new beat.
  assign in_ready = (~r_valid | out_ready) & ~flush;

  // Load on accept, return to bubble on a drain with nothing behind it.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_valid <= 1'b0;
      r_data  <= BUBBLE;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_data  <= BUBBLE;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_data  <= in_data;
    end else if (w_drain) begin
      r_valid <= 1'b0;
      r_data  <= BUBBLE;
    end
  end
`endif

  // Consecutive stalled cycles, saturating; any non-stalled cycle clears it.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_stall_cnt <= '0;
    end else if (flush) begin
      r_stall_cnt <= '0;
    end else if (out_valid && !out_ready) begin
      if (r_stall_cnt != c_cnt_max) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end else begin
      r_stall_cnt <= '0;
    end
  end

endmodule
`default_nettype wire
